// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit game LFSR: self-synchronises to the word stream,
// flywheels through corrupt words while locked, counts errors and drops lock on error bursts.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_word,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    state_t           state_q;
    logic [31:0]      last_q;
    logic [GW-1:0]    good_q;
    logic [BW-1:0]    bad_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] word_count_q;

    logic [31:0] pred_d;
    logic        nonzero_d;
    logic        hit_d;

    assign pred_d    = {last_q[30:0],
                        last_q[31] ^ last_q[28] ^ last_q[20] ^ last_q[13] ^
                        last_q[9]  ^ last_q[8]  ^ last_q[1]};
    // An all-zero word is the generator's lock-up state, so it can never count as a match.
    assign nonzero_d = |in_word;
    assign hit_d     = nonzero_d && (in_word == pred_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HUNT;
            last_q       <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    S_HUNT: begin
                        if (nonzero_d) begin
                            last_q  <= in_word;
                            good_q  <= '0;
                            state_q <= S_VERIFY;
                        end
                    end
                    S_VERIFY: begin
                        if (!nonzero_d) begin
                            state_q <= S_HUNT;
                        end else if (hit_d) begin
                            last_q <= in_word;
                            good_q <= good_q + 1'b1;
                            if (good_q == GW'(LOCK_COUNT - 1)) begin
                                state_q  <= S_LOCKED;
                                locked_q <= 1'b1;
                                bad_q    <= '0;
                            end
                        end else begin
                            last_q <= in_word;
                            good_q <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (word_count_q != '1)
                            word_count_q <= word_count_q + 1'b1;
                        if (hit_d) begin
                            last_q <= in_word;
                            bad_q  <= '0;
                        end else begin
                            // Flywheel: keep advancing on the prediction, discard the bad word.
                            last_q      <= pred_d;
                            bad_q       <= bad_q + 1'b1;
                            err_pulse_q <= 1'b1;
                            if (err_count_q != '1)
                                err_count_q <= err_count_q + 1'b1;
                            if (bad_q == BW'(UNLOCK_COUNT - 1)) begin
                                state_q  <= S_HUNT;
                                locked_q <= 1'b0;
                                last_q   <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= S_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // Clear takes priority over any count event in the same cycle.
            if (clr_cnt) begin
                err_count_q  <= '0;
                word_count_q <= '0;
            end
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus randomized streams, all outputs
// compared every cycle against a behavioural model of the lock/flywheel rules.
module tb_lfsr_seq_checker;
    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;
    localparam int CNT_W        = 6;   // narrow counters so saturation is reachable
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_word = '0;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    lfsr_seq_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    string            m_mode;      // "HUNT", "VERIFY", "LOCKED"
    logic [31:0]      m_last;
    int               m_good;
    int               m_bad;
    logic             m_locked;
    logic             m_pulse;
    logic [CNT_W-1:0] m_err;
    logic [CNT_W-1:0] m_words;

    function automatic logic [31:0] nxt(input logic [31:0] l);
        logic fb;
        fb = l[31] ^ l[28] ^ l[20] ^ l[13] ^ l[9] ^ l[8] ^ l[1];
        return (l << 1) | {31'd0, fb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "HUNT"; m_last = '0; m_good = 0; m_bad = 0;
        m_locked = 1'b0; m_pulse = 1'b0; m_err = '0; m_words = '0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [31:0] w, input logic c);
        logic [31:0] p;
        logic hit;
        if (r) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        if (v) begin
            p   = nxt(m_last);
            hit = (w != 0) && (w == p);
            if (m_mode == "HUNT") begin
                if (w != 0) begin m_last = w; m_good = 0; m_mode = "VERIFY"; end
            end else if (m_mode == "VERIFY") begin
                if (w == 0) m_mode = "HUNT";
                else if (hit) begin
                    m_last = w; m_good++;
                    if (m_good == LOCK_COUNT) begin m_mode = "LOCKED"; m_bad = 0; end
                end else begin m_last = w; m_good = 0; end
            end else begin
                if (m_words != CMAX) m_words++;
                if (hit) begin m_last = w; m_bad = 0; end
                else begin
                    m_last = p; m_bad++; m_pulse = 1'b1;
                    if (m_err != CMAX) m_err++;
                    if (m_bad == UNLOCK_COUNT) begin m_mode = "HUNT"; m_last = '0; end
                end
            end
        end
        if (c) begin m_err = '0; m_words = '0; end
        m_locked = (m_mode == "LOCKED");
    endtask

    // One clock: drive inputs, let the DUT sample, advance the model, return at the sampling edge.
    task automatic send(input logic v, input logic [31:0] w, input logic c, input logic r);
        rst = r; in_valid = v; in_word = w; clr_cnt = c;
        @(posedge clk);
        model_step(r, v, w, c);
        @(negedge clk);
    endtask

    task automatic word(input logic [31:0] w);
        send(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic ref_run();
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < 5; i++) begin word(s); s = nxt(s); end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",     {31'd0, locked},     {31'd0, m_locked});
            check("err_pulse",  {31'd0, err_pulse},  {31'd0, m_pulse});
            check("err_count",  32'(err_count),      32'(m_err));
            check("word_count", 32'(word_count),     32'(m_words));
        end
    end

    initial begin
        logic [31:0] gen, w;
        logic v, c, r;
        int burst;
        model_reset();

        // Model pins: the reference sequence from the generator
        check("nxt_1",  nxt(32'h1),  32'h2);
        check("nxt_2",  nxt(32'h2),  32'h5);
        check("nxt_15", nxt(32'h15), 32'h2A);
        check("nxt_2A", nxt(32'h2A), 32'h55);
        check("nxt_msb", nxt(32'h8000_0000), 32'h1);

        @(negedge clk);
        send(1'b0, '0, 1'b0, 1'b1);
        send(1'b0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_errcnt", 32'(err_count), 32'd0);
        check("reset_wordcnt", 32'(word_count), 32'd0);
        check("reset_pulse", {31'd0, err_pulse}, 32'd0);

        // Lock on the reference run, locked the cycle after the 5th word
        word(32'h1); word(32'h2); word(32'h5); word(32'hA);
        check("t1_not_yet", {31'd0, locked}, 32'd0);
        word(32'h15);
        check("t1_locked", {31'd0, locked}, 32'd1);
        check("t1_errcnt", 32'(err_count), 32'd0);

        // Single corrupt word: one pulse, flywheel keeps lock, next true word matches
        word(32'h1234_5678);
        check("t2_pulse", {31'd0, err_pulse}, 32'd1);
        check("t2_errcnt", 32'(err_count), 32'd1);
        check("t2_locked", {31'd0, locked}, 32'd1);
        word(32'h55);
        check("t2_pulse_gone", {31'd0, err_pulse}, 32'd0);
        check("t2_errcnt_hold", 32'(err_count), 32'd1);
        check("t2_wordcnt", 32'(word_count), 32'd2);

        // Three corrupt words in a row drop lock; a fresh run relocks
        word(32'hDEAD_BEEF); word(32'h0); word(32'hCAFE_F00D);
        check("t3_errcnt", 32'(err_count), 32'd4);
        check("t3_unlocked", {31'd0, locked}, 32'd0);
        ref_run();
        check("t3_relocked", {31'd0, locked}, 32'd1);

        // Reset mid-lock with two errors counted
        send(1'b0, '0, 1'b0, 1'b1);
        ref_run();
        word(32'h0BAD_0BAD); word(32'h55);  word(32'h0BAD_0BAD);
        check("t6_pre_errcnt", 32'(err_count), 32'd2);
        send(1'b1, 32'h1, 1'b0, 1'b1);
        check("t6_locked", {31'd0, locked}, 32'd0);
        check("t6_errcnt", 32'(err_count), 32'd0);
        check("t6_wordcnt", 32'(word_count), 32'd0);
        check("t6_pulse", {31'd0, err_pulse}, 32'd0);

        // Zero stream never locks
        for (int i = 0; i < 20; i++) word(32'h0);
        check("t4_locked", {31'd0, locked}, 32'd0);
        check("t4_errcnt", 32'(err_count), 32'd0);

        // Gapped valid: lock counted in valid words only
        gen = 32'h1;
        for (int i = 0; i < 5; i++) begin
            word(gen); gen = nxt(gen);
            send(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
            if (i < 4) check("t5_not_yet", {31'd0, locked}, 32'd0);
        end
        check("t5_locked", {31'd0, locked}, 32'd1);

        // Saturation: alternate bad/good words while locked (gen is the next true word)
        for (int i = 0; i < 2 * int'(CMAX) + 4; i++) begin
            word(32'h7777_7777); gen = nxt(gen);
            word(gen);           gen = nxt(gen);
        end
        check("sat_errcnt", 32'(err_count), 32'(CMAX));
        check("sat_wordcnt", 32'(word_count), 32'(CMAX));
        check("sat_locked", {31'd0, locked}, 32'd1);
        send(1'b1, 32'h7777_7777, 1'b1, 1'b0); gen = nxt(gen);
        check("clr_errcnt", 32'(err_count), 32'd0);
        check("clr_pulse", {31'd0, err_pulse}, 32'd1);
        check("clr_locked", {31'd0, locked}, 32'd1);

        // Randomized streams with corruption, zeros, gaps, clears, reseeds and rare resets
        burst = 0;
        gen = $urandom | 32'h1;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 149) == 0);
            w = $urandom;
            if (v) begin
                if ($urandom_range(0, 299) == 0) gen = $urandom | 32'h1;
                if ($urandom_range(0, 249) == 0) burst = UNLOCK_COUNT;
                w = gen; gen = nxt(gen);
                if (burst > 0) begin
                    w = $urandom; burst--;
                end else if ($urandom_range(0, 99) < 6) begin
                    w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                end
            end
            send(v, w, c, r);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
